// File: rtl/cmd_sender.sv
// cmd_sender: initiator side of the two-byte command link.
// Sends a 16-bit command on TX as two 8N1 frames, high byte first and with no gap between them.
// It then waits for a one-byte 8N1 response on RX and presents that byte to the host.
//
// Optional response timeout: define CMD_SENDER_TMO_EN. Without it, tmo is tied 0 and
// WAIT_RESP waits until a valid response arrives or reset is asserted.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   snd_cmd       single-cycle send request, accepted only when idle
//   cmd           command word, captured on acceptance
//   clr_resp_rdy  clears resp_rdy (a simultaneous set wins)
//   RX            asynchronous serial response line, idle high
//   TX            registered serial command line, idle high
//   busy          high from acceptance until the response or timeout
//   cmd_sent      both bytes fully transmitted
//   resp          last valid response byte
//   resp_rdy      resp holds a fresh byte
//   tmo           response timeout (only when CMD_SENDER_TMO_EN is defined)
module cmd_sender #(
  parameter int unsigned BAUD_DIV = 2604,
  parameter int unsigned TMO_BITS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        snd_cmd,
  input  logic [15:0] cmd,
  input  logic        clr_resp_rdy,
  input  logic        RX,
  output logic        TX,
  output logic        busy,
  output logic        cmd_sent,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  output logic        tmo
);

  localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] TX_HIGH   = 2'd1;
  localparam logic [1:0] TX_LOW    = 2'd2;
  localparam logic [1:0] WAIT_RESP = 2'd3;

  if (BAUD_DIV < 4 || (BAUD_DIV % 2) != 0 || TMO_BITS < 1) begin : g_bad_param
    $error("cmd_sender: BAUD_DIV must be even and >= 4, TMO_BITS >= 1");
  end

  logic [1:0]    state_q, state_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          cmd_sent_q, cmd_sent_d;
  logic [7:0]    resp_q, resp_d;
  logic          resp_rdy_q, resp_rdy_d;

  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic          rx_act_q, rx_act_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [3:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;

  logic          rx_fall;
  logic          rx_sample;
  logic          rx_ok;
  logic [7:0]    cur_byte;

`ifdef CMD_SENDER_TMO_EN
  logic [CW-1:0]       tmo_div_q, tmo_div_d;
  logic [TMO_BITS-1:0] tmo_cnt_q, tmo_cnt_d;
  logic                tmo_q, tmo_d;
`endif

  assign rx_fall  = rx_prev_q & ~rx_s2_q;
  // The shadow holds the command for the whole transaction; the state selects the byte on the wire.
  assign cur_byte = (state_q == TX_HIGH) ? shadow_q[15:8] : shadow_q[7:0];

  // Response receiver. It only runs in WAIT_RESP and is held idle in every other state.
  always_comb begin
    rx_act_d   = rx_act_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_ok      = 1'b0;
    rx_sample  = (rx_bit_q == 4'd0) ? (rx_cnt_q == HALF_M1) : (rx_cnt_q == CNT_MAX);
    if (state_q != WAIT_RESP) begin
      rx_act_d = 1'b0;
      rx_cnt_d = '0;
      rx_bit_d = '0;
    end else if (!rx_act_q) begin
      if (rx_fall) begin
        rx_act_d = 1'b1;
        rx_cnt_d = '0;
        rx_bit_d = '0;
      end
    end else if (!rx_sample) begin
      rx_cnt_d = rx_cnt_q + 1'b1;
    end else begin
      rx_cnt_d = '0;
      if (rx_bit_q == 4'd0) begin
        // A start bit that is high again at mid-bit is a false start.
        if (rx_s2_q) rx_act_d = 1'b0;
        else         rx_bit_d = 4'd1;
      end else if (rx_bit_q <= 4'd8) begin
        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 4'd1;
      end else begin
        // A stop bit sampled low is a framing error, so the byte is dropped.
        rx_act_d = 1'b0;
        rx_bit_d = '0;
        rx_ok    = rx_s2_q;
      end
    end
  end

  // Main FSM, transmit serializer and host flags.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    cmd_sent_d = cmd_sent_q;
    resp_d     = resp_q;
    resp_rdy_d = resp_rdy_q;
`ifdef CMD_SENDER_TMO_EN
    tmo_d      = tmo_q;
    tmo_div_d  = '0;
    tmo_cnt_d  = '0;
`endif

    if (clr_resp_rdy) resp_rdy_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (snd_cmd) begin
          shadow_d   = cmd;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          cmd_sent_d = 1'b0;
          resp_rdy_d = 1'b0;
`ifdef CMD_SENDER_TMO_EN
          tmo_d      = 1'b0;
`endif
          state_d    = TX_HIGH;
        end
      end
      TX_HIGH, TX_LOW: begin
        if (tx_cnt_q != CNT_MAX) begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end else begin
          tx_cnt_d = '0;
          if (tx_bit_q == 4'd9) begin
            tx_bit_d = '0;
            if (state_q == TX_HIGH) begin
              // The low byte's start bit follows the high byte's stop bit directly.
              tx_d    = 1'b0;
              state_d = TX_LOW;
            end else begin
              tx_d       = 1'b1;
              cmd_sent_d = 1'b1;
              state_d    = WAIT_RESP;
            end
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
            tx_d     = (tx_bit_q == 4'd8) ? 1'b1 : cur_byte[tx_bit_q[2:0]];
          end
        end
      end
      WAIT_RESP: begin
`ifdef CMD_SENDER_TMO_EN
        // The timeout counter is frozen while a response frame is being received.
        tmo_div_d = tmo_div_q;
        tmo_cnt_d = tmo_cnt_q;
        if (!rx_act_q) begin
          if (tmo_div_q == CNT_MAX) begin
            tmo_div_d = '0;
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end else begin
            tmo_div_d = tmo_div_q + 1'b1;
          end
        end
`endif
        if (rx_ok) begin
          busy_d  = 1'b0;
          state_d = IDLE;
`ifdef CMD_SENDER_TMO_EN
        end else if (&tmo_cnt_q && !rx_act_q) begin
          tmo_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // A newly received byte takes priority over clr_resp_rdy in the same cycle.
    if (rx_ok) begin
      resp_d     = rx_shift_q;
      resp_rdy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      cmd_sent_q <= 1'b0;
      resp_q     <= '0;
      resp_rdy_q <= 1'b0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_act_q   <= 1'b0;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      cmd_sent_q <= cmd_sent_d;
      resp_q     <= resp_d;
      resp_rdy_q <= resp_rdy_d;
      rx_s1_q    <= RX;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_act_q   <= rx_act_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

`ifdef CMD_SENDER_TMO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_div_q <= '0;
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_div_q <= tmo_div_d;
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_d;
    end
  end

  assign tmo = tmo_q;
`else
  assign tmo = 1'b0;
`endif

  assign TX       = tx_q;
  assign busy     = busy_q;
  assign cmd_sent = cmd_sent_q;
  assign resp     = resp_q;
  assign resp_rdy = resp_rdy_q;

endmodule
